regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file for the rv32 core's decode stage, replacing the single-port register block.
- Provides NRD asynchronous read ports and one synchronous write port.
- Register 0 is hard-wired to zero.
- Contents are cleared by a sequential scrub state machine after reset or on request; `ready` indicates the file is usable.

---
 rtl/regfile_mp_if.sv | 20 ++
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Write/read/scrub bus of the multi-read-port register file.
// The master drives requests; the slave (regfile_mp) returns read data and ready.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic                  we;
  logic [AW-1:0]         waddr;
  logic [XLEN-1:0]       wdata;
  logic [NRD*AW-1:0]     raddr;
  logic [NRD*XLEN-1:0]   rdata;
  logic                  clr_req;
  logic                  ready;

  modport master (output we, waddr, wdata, raddr, clr_req, input rdata, ready);
  modport slave  (input we, waddr, wdata, raddr, clr_req, output rdata, ready);
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with x0 hard-wired to zero and a scrub FSM.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_if.slave   bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Bit i set when index i is a real, writable register (not x0, below NREG).
  function automatic logic [(1<<AW)-1:0] idx_ok_mask();
    logic [(1<<AW)-1:0] m;
    m = '0;
    for (int i = 1; i < (1 << AW); i++)
      if (i < NREG) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [(1<<AW)-1:0] IDX_OK = idx_ok_mask();

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] regarr_q [NREG];
  logic [XLEN-1:0] regarr_d [NREG];
  logic            wr_ok;
  logic [NRD-1:0][XLEN-1:0] rdata_v;

  assign wr_ok = bus.we && IDX_OK[bus.waddr] && ready_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
          ptr_d   = '0;
        end
      end
      default: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
          ready_d = 1'b0;
        end
      end
    endcase
  end

  // Storage is left untouched while reset is held; the scrub clears it afterwards.
  always_comb begin
    regarr_d = regarr_q;
    if (rst_n) begin
      if (state_q == CLEAR) regarr_d[ptr_q] = '0;
      else if (wr_ok)       regarr_d[bus.waddr] = bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    regarr_q <= regarr_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    assign ra = bus.raddr[i*AW +: AW];
    always_comb begin
      rd = '0;
      if (ready_q && IDX_OK[ra]) begin
        if (BYP && wr_ok && (ra == bus.waddr)) rd = bus.wdata;
        else                                   rd = regarr_q[ra];
      end
    end
    assign rdata_v[i] = rd;
  end

  assign bus.rdata = rdata_v;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp: a 32x32/2-port and a 24x16/3-port
// instance run side by side against an array-based reference model.
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        we_v  [2];
  logic [4:0]  wa_v  [2];
  logic [31:0] wd_v  [2];
  logic [4:0]  ra_v  [2][3];
  logic        clr_v [2];

  int          left [2];
  logic [31:0] mem  [2][32];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 1'b0;

  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bus_a ();
  regfile_mp_if #(.XLEN(16), .NREG(24), .NRD(3)) bus_b ();

  assign bus_a.we      = we_v[0];
  assign bus_a.waddr   = wa_v[0];
  assign bus_a.wdata   = wd_v[0];
  assign bus_a.raddr   = {ra_v[0][1], ra_v[0][0]};
  assign bus_a.clr_req = clr_v[0];
  assign bus_b.we      = we_v[1];
  assign bus_b.waddr   = wa_v[1];
  assign bus_b.wdata   = wd_v[1][15:0];
  assign bus_b.raddr   = {ra_v[1][2], ra_v[1][1], ra_v[1][0]};
  assign bus_b.clr_req = clr_v[1];

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  regfile_mp #(.XLEN(16), .NREG(24), .NRD(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nreg(int d);
    return (d == 0) ? 32 : 24;
  endfunction

  function automatic logic [31:0] msk(int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Reference read: zero while scrubbing or for x0 / out-of-range, else stored value.
  function automatic logic [31:0] exp_rd(int d, int p);
    int a;
    a = int'(ra_v[d][p]);
    if (left[d] != 0 || a == 0 || a >= nreg(d)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we_v[d] && int'(wa_v[d]) == a) return wd_v[d] & msk(d);
`endif
    return mem[d][a];
  endfunction

  function automatic logic [31:0] obs_rd(int d, int p);
    if (d == 0) return bus_a.rdata[p*32 +: 32];
    return {16'h0, bus_b.rdata[p*16 +: 16]};
  endfunction

  task automatic check_all();
    #1;
    for (int p = 0; p < 2; p++) chk($sformatf("a_rd%0d", p), obs_rd(0, p), exp_rd(0, p));
    for (int p = 0; p < 3; p++) chk($sformatf("b_rd%0d", p), obs_rd(1, p), exp_rd(1, p));
    chk("a_ready", {31'h0, bus_a.ready}, {31'h0, left[0] == 0});
    chk("b_ready", {31'h0, bus_b.ready}, {31'h0, left[1] == 0});
  endtask

  // Scrub is modelled as a countdown of NREG edges ending in an all-zero file.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) left[d] = nreg(d);
      else if (left[d] > 0) begin
        left[d]--;
        if (left[d] == 0)
          for (int r = 0; r < 32; r++) mem[d][r] = 32'h0;
      end else begin
        if (we_v[d] && wa_v[d] != 0 && int'(wa_v[d]) < nreg(d))
          mem[d][wa_v[d]] = wd_v[d] & msk(d);
        if (clr_v[d]) left[d] = nreg(d);
      end
    end
  endtask

  task automatic step();
    if (chk_en) check_all();
    else #1;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      we_v[d]  = 1'b0;
      clr_v[d] = 1'b0;
    end
  endtask

  task automatic wr(int d, int a, logic [31:0] v);
    we_v[d] = 1'b1;
    wa_v[d] = a[4:0];
    wd_v[d] = v;
    step();
    we_v[d] = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    idle();
    for (int d = 0; d < 2; d++) begin
      wa_v[d] = '0;
      wd_v[d] = '0;
      left[d] = nreg(d);
      for (int p = 0; p < 3; p++) ra_v[d][p] = '0;
    end
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    chk("rst_ready_a", {31'h0, bus_a.ready}, 32'h0);

    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 31) chk("a_ready_e31", {31'h0, bus_a.ready}, 32'h0);
      if (i == 32) chk("a_ready_e32", {31'h0, bus_a.ready}, 32'h1);
      if (i == 23) chk("b_ready_e23", {31'h0, bus_b.ready}, 32'h0);
      if (i == 24) chk("b_ready_e24", {31'h0, bus_b.ready}, 32'h1);
    end

    for (int i = 0; i < 32; i++) begin
      ra_v[0][0] = i[4:0];
      ra_v[0][1] = 5'(31 - i);
      ra_v[1][0] = i[4:0];
      ra_v[1][1] = i[4:0] ^ 5'd5;
      ra_v[1][2] = 5'(31 - i);
      step();
    end

    wr(0, 5, 32'hDEAD_BEEF);
    wr(0, 6, 32'h1234_5678);
    ra_v[0][0] = 5'd5;
    ra_v[0][1] = 5'd6;
    #1;
    chk("x5_p0", obs_rd(0, 0), 32'hDEAD_BEEF);
    chk("x6_p1", obs_rd(0, 1), 32'h1234_5678);
    ra_v[0][1] = 5'd5;
    #1;
    chk("x5_same", obs_rd(0, 1), 32'hDEAD_BEEF);
    step();

    wr(0, 0, 32'hFFFF_FFFF);
    ra_v[0][0] = 5'd0;
    #1;
    chk("x0_zero", obs_rd(0, 0), 32'h0);
    step();

    wr(0, 7, 32'h1);
    ra_v[0][0] = 5'd7;
    we_v[0] = 1'b1;
    wa_v[0] = 5'd7;
    wd_v[0] = 32'h2;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x7_fwd", obs_rd(0, 0), 32'h2);
`else
    chk("x7_old", obs_rd(0, 0), 32'h1);
`endif
    step();
    we_v[0] = 1'b0;
    #1;
    chk("x7_new", obs_rd(0, 0), 32'h2);

    wr(0, 9, 32'h55);
    clr_v[0] = 1'b1;
    we_v[0]  = 1'b1;
    wa_v[0]  = 5'd10;
    wd_v[0]  = 32'h66;
    step();
    idle();
    chk("clr_ready_lo", {31'h0, bus_a.ready}, 32'h0);
    n = 0;
    while (bus_a.ready !== 1'b1 && n < 100) begin
      if (n == 4) begin
        we_v[0]  = 1'b1;
        wa_v[0]  = 5'd3;
        wd_v[0]  = 32'hA5A5_A5A5;
        clr_v[0] = 1'b1;
      end else idle();
      step();
      n++;
    end
    idle();
    chk("clr_len", n, 32);
    ra_v[0][0] = 5'd9;
    ra_v[0][1] = 5'd10;
    #1;
    chk("x9_clr", obs_rd(0, 0), 32'h0);
    chk("x10_clr", obs_rd(0, 1), 32'h0);
    ra_v[0][0] = 5'd3;
    #1;
    chk("x3_drop", obs_rd(0, 0), 32'h0);
    step();

    wr(1, 30, 32'hBEEF);
    ra_v[1][0] = 5'd30;
    #1;
    chk("b_x30", obs_rd(1, 0), 32'h0);
    wr(1, 1, 32'h1111);
    wr(1, 2, 32'h2222);
    wr(1, 23, 32'h2323);
    ra_v[1][0] = 5'd1;
    ra_v[1][1] = 5'd2;
    ra_v[1][2] = 5'd23;
    #1;
    chk("b_x1", obs_rd(1, 0), 32'h1111);
    chk("b_x2", obs_rd(1, 1), 32'h2222);
    chk("b_x23", obs_rd(1, 2), 32'h2323);
    step();

    for (int k = 0; k < 500; k++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      for (int d = 0; d < 2; d++) begin
        we_v[d]  = $urandom_range(0, 1) != 0;
        clr_v[d] = $urandom_range(0, 79) == 0;
        wa_v[d]  = 5'($urandom_range(0, 31));
        wd_v[d]  = $urandom;
        for (int p = 0; p < 3; p++) ra_v[d][p] = 5'($urandom_range(0, 31));
      end
      step();
    end
    rst_n = 1'b1;
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
